dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port data memory (1024 x 32).
//  - Port 0: core load/store stage. Port 1: loader/debug port.
//  - Serialises requests, one access per clock. Drives the memory's write enable, word address and write data.
//  - Returns registered read data to the winning requester.
// PARAMETERS
//  AW        10  word-address width; memory depth = 2**AW
//  DW        32  data width
//  LOCK_MAX   4  max consecutive grants to one locked requester before forced rotation (1..15)
// PORTS
//  clk2        in   1   clock, posedge-driven; memory writes on following negedge
//  rst         in   1   asynchronous reset, active-high
//  req0/req1   in   1   access request; held with addr/we/wdata until gnt
//  we0/we1     in   1   1=write, 0=read
//  lock0/lock1 in   1   request back-to-back grants (burst)
//  addr0/addr1 in   32  word address; only [AW-1:0] drives memory
//  wdata0/1    in   DW  write data
//  gnt0/gnt1   out  1   access performed this cycle (one-cycle pulse)
//  rvalid0/1   out  1   read data valid, cycle after gnt of a read
//  rdata0/1    out  DW  registered read data, held until next rvalid on that port
//  mem_en_w    out  1   memory write enable
//  mem_addr    out  32  memory address, zero-extended from AW bits
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory combinational read data
//  err         out  1   only with DMEM_ARB_BOUND_CHECK_EN; else tied 0
// BEHAVIOUR
//  - Reset: state=IDLE, last=1 (port 0 wins first tie), lock_cnt=0. All gnt/rvalid/err/mem_en_w=0; rdata/mem_addr/mem_wdata=0.
//  - FSM, 2 states:
//    - IDLE: any req at posedge -> latch winner's we/addr/wdata into access regs, go BUSY.
//    - BUSY: gnt<winner>=1; mem_* driven from access regs; mem_en_w=we.
//      - At posedge: if read, rdata<winner><=mem_rdata and rvalid<winner><=1 for one cycle.
//      - Next: re-arbitrate (back-to-back BUSY) if any req still asserted excluding the one just granted, else IDLE.
//  - Latency: req seen at edge N -> gnt in cycle N+1 -> rvalid in cycle N+2. Sustained throughput 1 access/cycle.
//  - Requester drops req in the cycle after gnt, or keeps it for a new access (new addr/data allowed then).
//  - Arbitration: round-robin; winner = port != last when both request; last <= winner on every grant.
//  - Lock: winner with lockX=1 and reqX=1 keeps the grant while lock_cnt < LOCK_MAX-1.
//    - lock_cnt increments per locked grant; cleared on rotation or lock drop.
//    - At LOCK_MAX consecutive grants the other port wins if requesting; otherwise the lock continues and lock_cnt saturates.
//  - Simultaneous rvalid on one port and gnt on the other is legal. gnt0 and gnt1 are never both 1.
//  - mem_en_w is 0 in IDLE and for reads; never asserted in a cycle without gnt.
//  - Reset mid-access: everything to reset values immediately. An in-flight write is dropped only if rst rises before the negedge.
//  - Address bits above AW-1 ignored (wrap modulo 2**AW) unless bound check enabled.
// CONFIGURATION
//  DMEM_ARB_BOUND_CHECK_EN defined:
//    - addr[31:AW]!=0 -> access still granted (gnt=1) but mem_en_w forced 0.
//    - Read returns 0 with rvalid; err=1 for that gnt cycle.
//  Not defined: no check; err=0 constant; addresses wrap.
// TESTING
//  1 Reset: rst=1 mid-BUSY -> gnt*/rvalid*/mem_en_w/err=0 same cycle; after release req0+req1 together -> gnt0 first.
//  2 Single write/read: req0 we0=1 addr0=5 wdata0=0xDEADBEEF -> gnt0, mem_en_w=1 one cycle; then read addr 5 -> rvalid0, rdata0=0xDEADBEEF two cycles after req.
//  3 Contention: req0,req1 held continuously, no lock -> gnt alternates 0,1,0,1 every cycle, no idle cycles.
//  4 Lock: lock1=1, req0,req1 held, LOCK_MAX=4 -> gnt1 x4, gnt0 x1, gnt1 x4 ...
//  5 Wrap/bound: write addr0=0x400 data 0x11 -> undefined macro: mem_addr=0, word 0=0x11; defined: err=1, mem_en_w=0, word 0 unchanged.
//  6 Back-to-back mixed: port0 read A while port1 writes A next cycle -> rdata0 = old value of A, later read returns new value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter/sequencer in front of a single-port data memory
// (2**AW words of DW bits). Port 0 is the core load/store stage, port 1 the
// loader/debug port. One access is performed per clock. The memory is written
// on the negedge that follows the grant cycle. Read data comes back registered
// on the cycle after the grant.
//
// Optional feature macro: DMEM_ARB_BOUND_CHECK_EN
//   defined   : an address with any bit set above AW-1 is still granted, but
//               the write is suppressed, a read returns 0 and err pulses with
//               the grant.
//   undefined : no check, err is tied 0 and addresses wrap modulo 2**AW.
//
// Handshake: a requester raises reqX and holds weX/addrX/wdataX/lockX stable
// until it sees gntX (a one-cycle pulse in the cycle the access is performed).
// In the cycle after gntX it either drops reqX or presents a new access.
// A read returns rvalidX for one cycle, one cycle after gntX. rdataX holds
// its value until the next rvalidX on that port.
//
// Ports
//   clk2              in   clock, posedge-driven
//   rst               in   asynchronous reset, active-high
//   req0/req1         in   access request
//   we0/we1           in   1 = write, 0 = read
//   lock0/lock1       in   ask for back-to-back grants (burst)
//   addr0/addr1       in   32-bit word address, [AW-1:0] drives the memory
//   wdata0/wdata1     in   write data
//   gnt0/gnt1         out  access performed this cycle
//   rvalid0/rvalid1   out  read data valid
//   rdata0/rdata1     out  registered read data
//   mem_en_w          out  memory write enable
//   mem_addr          out  memory word address, zero-extended from AW bits
//   mem_wdata         out  memory write data
//   mem_rdata         in   memory combinational read data
//   err               out  out-of-range access flag (bound check build only)
//   state_dbg         out  FSM state: 0 = IDLE, 1 = BUSY
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk2,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [31:0]   addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [31:0]   addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en_w,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic          state_dbg
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Highest lock_cnt value; a locked winner keeps the grant while below it.
    localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX - 1);

    state_t        state_q,     state_d;
    logic          last_q,      last_d;
    logic [3:0]    lock_cnt_q,  lock_cnt_d;
    logic          acc_port_q,  acc_port_d;
    logic          acc_we_q,    acc_we_d;
    logic [AW-1:0] acc_addr_q,  acc_addr_d;
    logic [DW-1:0] acc_wdata_q, acc_wdata_d;
    logic          rvalid0_q,   rvalid0_d;
    logic          rvalid1_q,   rvalid1_d;
    logic [DW-1:0] rdata0_q,    rdata0_d;
    logic [DW-1:0] rdata1_q,    rdata1_d;

    logic          busy;
    logic          grant_now;   // an access is launched for the next cycle
    logic          win;         // port that receives that access
    logic          same_req;
    logic          same_lock;
    logic          other_req;
    logic [DW-1:0] rd_capture;

    assign busy = (state_q == ST_BUSY);

    // -------------------------------------------------------------------------
    // Optional bound check
    // -------------------------------------------------------------------------
`ifdef DMEM_ARB_BOUND_CHECK_EN
    logic acc_oob_q, acc_oob_d;
    logic win_oob;

    assign win_oob = win ? (|addr1[31:AW]) : (|addr0[31:AW]);

    always_comb begin
        acc_oob_d = acc_oob_q;
        if (grant_now) begin
            acc_oob_d = win_oob;
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            acc_oob_q <= 1'b0;
        end else begin
            acc_oob_q <= acc_oob_d;
        end
    end

    // Out-of-range accesses still consume a grant but never touch memory.
    assign rd_capture = acc_oob_q ? '0 : mem_rdata;
    assign mem_en_w   = busy && acc_we_q && !acc_oob_q;
    assign err        = busy && acc_oob_q;
`else
    logic unused_addr_hi;

    // High address bits are ignored: the access wraps modulo 2**AW.
    assign unused_addr_hi = ^{addr0[31:AW], addr1[31:AW]};
    assign rd_capture     = mem_rdata;
    assign mem_en_w       = busy && acc_we_q;
    assign err            = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state / arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lock_cnt_d  = lock_cnt_q;
        acc_port_d  = acc_port_q;
        acc_we_d    = acc_we_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        grant_now   = 1'b0;
        win         = 1'b0;
        same_req    = acc_port_q ? req1  : req0;
        same_lock   = acc_port_q ? lock1 : lock0;
        other_req   = acc_port_q ? req0  : req1;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_now  = 1'b1;
                    // On a tie the port that was not served last wins.
                    win        = (req0 && req1) ? ~last_q : req1;
                    lock_cnt_d = 4'd0;
                end
            end

            ST_BUSY: begin
                if (!acc_we_q) begin
                    if (acc_port_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = rd_capture;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = rd_capture;
                    end
                end

                // The just-granted port's req refers to the access that was
                // just performed, so it only counts again as a locked burst.
                if (same_req && same_lock &&
                    ((lock_cnt_q < LOCK_LIMIT) || !other_req)) begin
                    grant_now = 1'b1;
                    win       = acc_port_q;
                    if (lock_cnt_q < LOCK_LIMIT) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end
                end else if (other_req) begin
                    grant_now  = 1'b1;
                    win        = ~acc_port_q;
                    lock_cnt_d = 4'd0;
                end else begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = 4'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_now) begin
            state_d     = ST_BUSY;
            last_d      = win;
            acc_port_d  = win;
            acc_we_d    = win ? we1 : we0;
            acc_addr_d  = win ? addr1[AW-1:0] : addr0[AW-1:0];
            acc_wdata_d = win ? wdata1 : wdata0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            lock_cnt_q  <= 4'd0;
            acc_port_q  <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            acc_port_q  <= acc_port_d;
            acc_we_q    <= acc_we_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt0      = busy && !acc_port_q;
    assign gnt1      = busy &&  acc_port_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = {{(32-AW){1'b0}}, acc_addr_q};
    assign mem_wdata = acc_wdata_q;
    assign state_dbg = busy;

endmodule
